// File: rtl/sram_arbiter_if.sv
// Requester and SRAM side signals of the work-SRAM arbiter.
// The master modport is the requester/SRAM side; the slave modport is the arbiter.
interface sram_arbiter_if #(
    parameter int AW = 17
);
    logic          dl_active;
    logic          dl_req;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_ack;

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [7:0]    vid_rdata;
    logic          vid_rvalid;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          cpu_rvalid;
    logic          cpu_hold;

    logic [AW-1:0] sram_addr;
    logic          sram_we;
    logic [7:0]    sram_do;
    logic [7:0]    sram_di;

    modport master (
        output dl_active, dl_req, dl_addr, dl_data,
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output sram_di,
        input  dl_ack, vid_ack, vid_rdata, vid_rvalid,
        input  cpu_ack, cpu_rdata, cpu_rvalid, cpu_hold,
        input  sram_addr, sram_we, sram_do
    );

    modport slave (
        input  dl_active, dl_req, dl_addr, dl_data,
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  sram_di,
        output dl_ack, vid_ack, vid_rdata, vid_rvalid,
        output cpu_ack, cpu_rdata, cpu_rvalid, cpu_hold,
        output sram_addr, sram_we, sram_do
    );
endinterface

// File: rtl/sram_arbiter.sv
// Fixed-priority arbiter for the shared work SRAM (download > starved CPU > video > CPU); ack 1 cycle
// after the grant cycle, read data 2 cycles; losers just keep req high (no drop) until acked.
module sram_arbiter #(
    parameter int AW           = 17,
    parameter int CPU_MAX_WAIT = 4,
    parameter int WCNT_W       = 3
) (
    input  logic          clk_sys,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {SRC_NONE, SRC_DL, SRC_VID, SRC_CPU} src_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU} tag_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [7:0]    dat;
    } acc_t;

    src_e              win;
    acc_t              acc;
    acc_t              acc_q;
    tag_e              tag_q;
    logic [WCNT_W-1:0] wcnt;
    logic              dl_ack_q, vid_ack_q, cpu_ack_q;
    logic              vid_rvalid_q, cpu_rvalid_q;
    logic [7:0]        vid_rdata_q, cpu_rdata_q;
    logic              hold_q;

    // A download window locks out both other requesters entirely.
    always_comb begin
        win = SRC_NONE;
        if (bus.dl_active) begin
            if (bus.dl_req) win = SRC_DL;
        end else if (bus.cpu_req && wcnt == WMAX) begin
            win = SRC_CPU;
        end else if (bus.vid_req) begin
            win = SRC_VID;
        end else if (bus.cpu_req) begin
            win = SRC_CPU;
        end
    end

    always_comb begin
        acc = '{addr: acc_q.addr, we: 1'b0, dat: acc_q.dat};
        case (win)
            SRC_DL:  acc = '{addr: bus.dl_addr,  we: 1'b1,       dat: bus.dl_data};
            SRC_VID: acc = '{addr: bus.vid_addr, we: 1'b0,       dat: acc_q.dat};
            SRC_CPU: acc = '{addr: bus.cpu_addr, we: bus.cpu_we, dat: bus.cpu_wdata};
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            acc_q        <= '0;
            tag_q        <= TAG_NONE;
            wcnt         <= '0;
            dl_ack_q     <= 1'b0;
            vid_ack_q    <= 1'b0;
            cpu_ack_q    <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            hold_q       <= 1'b0;
        end else begin
            acc_q     <= acc;
            dl_ack_q  <= (win == SRC_DL);
            vid_ack_q <= (win == SRC_VID);
            cpu_ack_q <= (win == SRC_CPU);
            hold_q    <= bus.dl_active;

            // The tag follows the access through the SRAM so the data lands on the right port.
            if (win == SRC_VID)                     tag_q <= TAG_VID;
            else if (win == SRC_CPU && !bus.cpu_we) tag_q <= TAG_CPU;
            else                                    tag_q <= TAG_NONE;

            vid_rvalid_q <= (tag_q == TAG_VID);
            cpu_rvalid_q <= (tag_q == TAG_CPU);
            if (tag_q == TAG_VID) vid_rdata_q <= bus.sram_di;
            if (tag_q == TAG_CPU) cpu_rdata_q <= bus.sram_di;

            if (win == SRC_CPU || !bus.cpu_req) wcnt <= '0;
            else if (!bus.dl_active && wcnt != WMAX) wcnt <= wcnt + 1'b1;
        end
    end

    assign bus.sram_addr  = acc_q.addr;
    assign bus.sram_we    = acc_q.we & ~reset;
    assign bus.sram_do    = acc_q.dat;
    assign bus.dl_ack     = dl_ack_q;
    assign bus.vid_ack    = vid_ack_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.vid_rvalid = vid_rvalid_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.vid_rdata  = vid_rdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_hold   = hold_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a negedge-clocked SRAM model and per-port read scoreboards.
// Inputs are driven and outputs sampled 1 time unit after each falling clock edge.
module tb_sram_arbiter;
    localparam int AW = 17;

    logic clk_sys;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    typedef struct {
        int         cyc;
        logic [7:0] dat;
    } exp_t;

    exp_t vq[$];
    exp_t cq[$];

    logic [7:0]    mem [0:(1<<AW)-1];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_dat;

    sram_arbiter_if #(.AW(AW)) bus ();

    sram_arbiter #(.AW(AW), .CPU_MAX_WAIT(4), .WCNT_W(3)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // SRAM runs on the inverted clock: read-first, write on sram_we.
    always @(negedge clk_sys) begin
        if (bd_we) mem[bd_addr] <= bd_dat;
        else if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_do;
        bus.sram_di <= mem[bus.sram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
        cyc++;
        if (vq.size() > 0 && vq[0].cyc == cyc) begin
            chk("vid_rvalid", {31'd0, bus.vid_rvalid}, 32'd1);
            chk("vid_rdata", {24'd0, bus.vid_rdata}, {24'd0, vq[0].dat});
            void'(vq.pop_front());
        end else begin
            chk("vid_rvalid_spurious", {31'd0, bus.vid_rvalid}, 32'd0);
        end
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            chk("cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
            chk("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, cq[0].dat});
            void'(cq.pop_front());
        end else begin
            chk("cpu_rvalid_spurious", {31'd0, bus.cpu_rvalid}, 32'd0);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_dat  = d;
        bd_we   = 1'b1;
        @(negedge clk_sys);
        #1;
        bd_we   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        reset = 1'b1;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_dat  = '0;
        bus.dl_active = 1'b0; bus.dl_req = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        repeat (2) @(negedge clk_sys);
        #1;
        preload(17'h00100, 8'h5A);
        preload(17'h00300, 8'h3C);
        preload(17'h1F000, 8'hC7);

        // Reset values
        tick();
        chk("rst_dl_ack", {31'd0, bus.dl_ack}, 32'd0);
        chk("rst_vid_ack", {31'd0, bus.vid_ack}, 32'd0);
        chk("rst_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        chk("rst_sram_we", {31'd0, bus.sram_we}, 32'd0);
        chk("rst_sram_addr", {15'd0, bus.sram_addr}, 32'd0);
        chk("rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        reset = 1'b0;
        tick();

        // Single video read
        bus.vid_addr = 17'h00100;
        bus.vid_req  = 1'b1;
        vq.push_back('{cyc + 2, 8'h5A});
        tick();
        chk("t1_vid_ack", {31'd0, bus.vid_ack}, 32'd1);
        chk("t1_sram_we", {31'd0, bus.sram_we}, 32'd0);
        chk("t1_sram_addr", {15'd0, bus.sram_addr}, 32'h100);
        bus.vid_req = 1'b0;
        tick();
        chk("t1_vid_ack_off", {31'd0, bus.vid_ack}, 32'd0);
        chk("t1_sram_we2", {31'd0, bus.sram_we}, 32'd0);
        tick();

        // Download burst locks out CPU and video
        bus.dl_active = 1'b1; bus.dl_req = 1'b1; bus.dl_addr = 17'h0; bus.dl_data = 8'h11;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'h00300;
        bus.vid_req = 1'b1; bus.vid_addr = 17'h00100;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_dl_ack", {31'd0, bus.dl_ack}, 32'd1);
            chk("t2_sram_we", {31'd0, bus.sram_we}, 32'd1);
            chk("t2_sram_addr", {15'd0, bus.sram_addr}, 32'(i));
            chk("t2_sram_do", {24'd0, bus.sram_do}, 32'(8'h11 * (i + 1)));
            chk("t2_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
            chk("t2_vid_ack", {31'd0, bus.vid_ack}, 32'd0);
            chk("t2_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
            if (i < 3) begin
                bus.dl_addr = 17'(i + 1);
                bus.dl_data = 8'(8'h11 * (i + 2));
            end else begin
                bus.dl_req    = 1'b0;
                bus.dl_active = 1'b0;
            end
        end
        tick();
        chk("t2_vid_first", {31'd0, bus.vid_ack}, 32'd1);
        chk("t2_cpu_wait", {31'd0, bus.cpu_ack}, 32'd0);
        chk("t2_dl_ack_off", {31'd0, bus.dl_ack}, 32'd0);
        chk("t2_hold_off", {31'd0, bus.cpu_hold}, 32'd0);
        vq.push_back('{cyc + 1, 8'h5A});
        bus.vid_req = 1'b0;
        tick();
        chk("t2_cpu_ack_after", {31'd0, bus.cpu_ack}, 32'd1);
        chk("t2_cpu_addr", {15'd0, bus.sram_addr}, 32'h300);
        cq.push_back('{cyc + 1, 8'h3C});
        bus.cpu_req = 1'b0;
        tick();
        tick();

        // CPU starvation boost against continuous video
        bus.vid_req = 1'b1; bus.vid_addr = 17'h00100;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 17'h1F000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_vid_ack", {31'd0, bus.vid_ack}, 32'd1);
            chk("t3_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
            vq.push_back('{cyc + 1, 8'h5A});
        end
        chk("t3_wcnt_sat", {29'd0, dut.wcnt}, 32'd4);
        tick();
        chk("t3_cpu_boost", {31'd0, bus.cpu_ack}, 32'd1);
        chk("t3_vid_skip", {31'd0, bus.vid_ack}, 32'd0);
        chk("t3_sram_addr", {15'd0, bus.sram_addr}, 32'h1F000);
        cq.push_back('{cyc + 1, 8'hC7});
        bus.cpu_req = 1'b0;
        tick();
        chk("t3_vid_resume", {31'd0, bus.vid_ack}, 32'd1);
        chk("t3_wcnt_clr", {29'd0, dut.wcnt}, 32'd0);
        vq.push_back('{cyc + 1, 8'h5A});
        bus.vid_req = 1'b0;
        tick();
        tick();

        // CPU write followed by read-back
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 17'h00200; bus.cpu_wdata = 8'hA5;
        tick();
        chk("t4_wr_ack", {31'd0, bus.cpu_ack}, 32'd1);
        chk("t4_wr_we", {31'd0, bus.sram_we}, 32'd1);
        chk("t4_wr_addr", {15'd0, bus.sram_addr}, 32'h200);
        chk("t4_wr_do", {24'd0, bus.sram_do}, 32'hA5);
        bus.cpu_we = 1'b0;
        tick();
        chk("t4_rd_ack", {31'd0, bus.cpu_ack}, 32'd1);
        chk("t4_rd_we", {31'd0, bus.sram_we}, 32'd0);
        cq.push_back('{cyc + 1, 8'hA5});
        bus.cpu_req = 1'b0;
        tick();
        tick();

        // Download request outside a download window is ignored
        bus.dl_active = 1'b0; bus.dl_req = 1'b1; bus.dl_addr = 17'h00005; bus.dl_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_dl_ack", {31'd0, bus.dl_ack}, 32'd0);
            chk("t5_sram_we", {31'd0, bus.sram_we}, 32'd0);
        end
        bus.dl_req = 1'b0;
        tick();

        // Reset right after a video grant discards the read
        bus.vid_req = 1'b1; bus.vid_addr = 17'h00100;
        tick();
        chk("t6_vid_ack", {31'd0, bus.vid_ack}, 32'd1);
        bus.vid_req = 1'b0;
        reset = 1'b1;
        tick();
        chk("t6_vid_ack_rst", {31'd0, bus.vid_ack}, 32'd0);
        chk("t6_sram_we_rst", {31'd0, bus.sram_we}, 32'd0);
        chk("t6_sram_addr_rst", {15'd0, bus.sram_addr}, 32'd0);
        chk("t6_sram_do_rst", {24'd0, bus.sram_do}, 32'd0);
        chk("t6_vid_rdata_rst", {24'd0, bus.vid_rdata}, 32'd0);
        chk("t6_cpu_rdata_rst", {24'd0, bus.cpu_rdata}, 32'd0);
        chk("t6_cpu_hold_rst", {31'd0, bus.cpu_hold}, 32'd0);
        reset = 1'b0;
        tick();
        bus.vid_req = 1'b1; bus.vid_addr = 17'h1F000;
        vq.push_back('{cyc + 2, 8'hC7});
        tick();
        chk("t6_vid_ack_after", {31'd0, bus.vid_ack}, 32'd1);
        bus.vid_req = 1'b0;
        tick();
        tick();
        tick();

        chk("end_vid_queue", 32'(vq.size()), 32'd0);
        chk("end_cpu_queue", 32'(cq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
